fir_config_sequencer: RTL and testbench

Controller that sequences the team's `fir` block.
- Loads NTAPS coefficients via `coef_enable`/`data_in`, inserts a settle gap, then streams samples from an upstream valid/ready source into `sample_enable`/`data_in`.
- Captures FIR results, counts them and supervises the FIR `error` line.
- Sits between the stream/config sources and the FIR, so no other block toggles FIR enables directly.

---
 rtl/fir_config_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fir_config_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_config_sequencer.sv
// fir_config_sequencer: controller that sequences a fir block.
// It loads NTAPS coefficients, waits GAP idle cycles, then streams samples.
// It also captures FIR results, counts them and supervises the FIR error line.
//
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   cfg_start          : pulse that begins a (re)load of coefficients
//   cfg_coef/valid     : coefficient stream in; cfg_ready is decoded from state only
//   smp_in/valid       : sample stream in; smp_ready is decoded from state only
//   fir_data_in        : data word to the FIR (registered)
//   fir_coef_enable    : coefficient strobe to the FIR (registered)
//   fir_sample_enable  : sample strobe to the FIR (registered)
//   fir_data_out       : result word from the FIR
//   fir_out_enable     : result strobe from the FIR
//   fir_error          : error line from the FIR
//   res_data/res_valid : registered result and its one-cycle strobe
//   cfg_done           : one-cycle pulse on the first RUN cycle
//   busy               : high while in LOAD, GAP or RUN
//   err_flag           : sticky error indication
//   out_count          : number of results since the last cfg_start (wraps)
//
// Optional feature macro: FIR_SEQ_TIMEOUT_EN adds parameter TIMEOUT. When it is
// defined, LOAD errors out after TIMEOUT consecutive cycles without cfg_valid.
module fir_config_sequencer #(
    parameter int unsigned NTAPS = 10,
    parameter int unsigned DW    = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned GAP   = 1
`ifdef FIR_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_start,
    input  logic [DW-1:0] cfg_coef,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] smp_in,
    input  logic          smp_valid,
    output logic          smp_ready,
    output logic [DW-1:0] fir_data_in,
    output logic          fir_coef_enable,
    output logic          fir_sample_enable,
    input  logic [OW-1:0] fir_data_out,
    input  logic          fir_out_enable,
    input  logic          fir_error,
    output logic [OW-1:0] res_data,
    output logic          res_valid,
    output logic          cfg_done,
    output logic          busy,
    output logic          err_flag,
    output logic [15:0]   out_count
);

    localparam int unsigned CW = 8;
    localparam int unsigned GW = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] coef_cnt_q, coef_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          coef_en_q, coef_en_d;
    logic          smp_en_q, smp_en_d;
    logic [OW-1:0] res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          cfg_done_q, cfg_done_d;
    logic          busy_q, busy_d;
    logic          err_flag_q, err_flag_d;
    logic [15:0]   out_count_q, out_count_d;

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Readies depend on state only, never on the valid inputs.
    assign cfg_ready = (state_q == ST_LOAD);
    assign smp_ready = (state_q == ST_RUN);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        coef_cnt_d  = coef_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_d      = data_q;
        coef_en_d   = 1'b0;
        smp_en_d    = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        out_count_d = out_count_q;
        err_flag_d  = err_flag_q;
`ifdef FIR_SEQ_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif

        // Result capture is live in every state except ERR.
        if (fir_out_enable && (state_q != ST_ERR)) begin
            res_data_d  = fir_data_out;
            res_valid_d = 1'b1;
            out_count_d = out_count_q + 16'd1;
        end

        case (state_q)
            ST_LOAD: begin
                if (cfg_valid) begin
                    data_d     = cfg_coef;
                    coef_en_d  = 1'b1;
                    coef_cnt_d = coef_cnt_q + CW'(1);
`ifdef FIR_SEQ_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (coef_cnt_q == CW'(NTAPS - 1)) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end
`ifdef FIR_SEQ_TIMEOUT_EN
                else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d    = ST_ERR;
                    err_flag_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
`endif
            end
            // GAP spans the last coefficient cycle plus GAP idle cycles.
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP)) begin
                    state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_RUN: begin
                if (smp_valid) begin
                    data_d   = smp_in;
                    smp_en_d = 1'b1;
                end
            end
            default: ;
        endcase

        // fir_error beats cfg_start; a sample accepted alongside cfg_start is kept.
        if (fir_error && (state_q != ST_IDLE)) begin
            state_d    = ST_ERR;
            err_flag_d = 1'b1;
            coef_en_d  = 1'b0;
            smp_en_d   = 1'b0;
        end else if (cfg_start) begin
            state_d     = ST_LOAD;
            coef_cnt_d  = '0;
            out_count_d = '0;
            err_flag_d  = 1'b0;
            coef_en_d   = 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
            idle_cnt_d  = '0;
`endif
        end

        cfg_done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_GAP) || (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            coef_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            data_q      <= '0;
            coef_en_q   <= 1'b0;
            smp_en_q    <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            out_count_q <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            coef_cnt_q  <= coef_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            coef_en_q   <= coef_en_d;
            smp_en_q    <= smp_en_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            cfg_done_q  <= cfg_done_d;
            busy_q      <= busy_d;
            err_flag_q  <= err_flag_d;
            out_count_q <= out_count_d;
`ifdef FIR_SEQ_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign fir_data_in       = data_q;
    assign fir_coef_enable   = coef_en_q;
    assign fir_sample_enable = smp_en_q;
    assign res_data          = res_data_q;
    assign res_valid         = res_valid_q;
    assign cfg_done          = cfg_done_q;
    assign busy              = busy_q;
    assign err_flag          = err_flag_q;
    assign out_count         = out_count_q;

endmodule

// File: tb/tb_fir_config_sequencer.sv
// Testbench for fir_config_sequencer (NTAPS=10, DW=8, OW=16, GAP=1).
// Table-driven first load plus hand-written sequences; FIR strobes are
// checked against queues of expected words filled when stimulus is driven.
module tb_fir_config_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [7:0]  cfg_coef;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  smp_in;
    logic        smp_valid;
    logic        smp_ready;
    logic [7:0]  fir_data_in;
    logic        fir_coef_enable;
    logic        fir_sample_enable;
    logic [15:0] fir_data_out;
    logic        fir_out_enable;
    logic        fir_error;
    logic [15:0] res_data;
    logic        res_valid;
    logic        cfg_done;
    logic        busy;
    logic        err_flag;
    logic [15:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  coef_q[$];
    logic [7:0]  smp_q[$];
    logic [15:0] res_q[$];

    always #5 clk = ~clk;

    fir_config_sequencer #(
        .NTAPS(10), .DW(8), .OW(16), .GAP(1)
`ifdef FIR_SEQ_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_coef(cfg_coef), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .smp_in(smp_in), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .fir_data_in(fir_data_in), .fir_coef_enable(fir_coef_enable),
        .fir_sample_enable(fir_sample_enable),
        .fir_data_out(fir_data_out), .fir_out_enable(fir_out_enable), .fir_error(fir_error),
        .res_data(res_data), .res_valid(res_valid), .cfg_done(cfg_done), .busy(busy),
        .err_flag(err_flag), .out_count(out_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: strobe with data %0h, expected no strobe", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        check({tag, "_smp_ready"}, 32'(smp_ready), 32'd0);
        check({tag, "_data_in"},   32'(fir_data_in), 32'd0);
        check({tag, "_coef_en"},   32'(fir_coef_enable), 32'd0);
        check({tag, "_smp_en"},    32'(fir_sample_enable), 32'd0);
        check({tag, "_res_data"},  32'(res_data), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_cfg_done"},  32'(cfg_done), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_err_flag"},  32'(err_flag), 32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
    endtask

    task automatic drive_coef(input logic [7:0] c);
        cfg_valid = 1'b1;
        cfg_coef  = c;
        coef_q.push_back(c);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic drive_result(input logic [15:0] d);
        fir_out_enable = 1'b1;
        fir_data_out   = d;
        res_q.push_back(d);
        step();
        fir_out_enable = 1'b0;
    endtask

    // Scoreboard monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (fir_coef_enable) begin
            if (coef_q.size() == 0) unexpected("coef_strobe", 32'(fir_data_in));
            else check("coef_data", 32'(fir_data_in), 32'(coef_q.pop_front()));
        end
        if (fir_sample_enable) begin
            if (smp_q.size() == 0) unexpected("sample_strobe", 32'(fir_data_in));
            else check("sample_data", 32'(fir_data_in), 32'(smp_q.pop_front()));
        end
        if (res_valid) begin
            if (res_q.size() == 0) unexpected("res_strobe", 32'(res_data));
            else check("res_data", 32'(res_data), 32'(res_q.pop_front()));
        end
        if (fir_coef_enable || fir_sample_enable)
            check("enable_overlap", 32'(fir_coef_enable && fir_sample_enable), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] coef;
        logic       e_cfg_ready;
        logic       e_smp_ready;
        logic       e_coef_en;
        logic [7:0] e_data;
        logic       e_cfg_done;
        logic       e_busy;
    } vec_t;

    vec_t vecs[14];
    logic [15:0] run_res[5];

    initial begin
        // Vectors: cfg_start, ten coefficients 4..13, one idle GAP cycle, RUN.
        for (int i = 0; i < 14; i++) begin
            vecs[i].start       = (i == 0);
            vecs[i].valid       = (i >= 1) && (i <= 10);
            vecs[i].coef        = (i >= 1 && i <= 10) ? 8'(i + 3) : 8'd0;
            vecs[i].e_cfg_ready = (i <= 9);
            vecs[i].e_smp_ready = (i >= 12);
            vecs[i].e_coef_en   = (i >= 1) && (i <= 10);
            vecs[i].e_data      = (i == 0) ? 8'd0 : ((i <= 10) ? 8'(i + 3) : 8'd13);
            vecs[i].e_cfg_done  = (i == 12);
            vecs[i].e_busy      = 1'b1;
        end
        run_res[0] = 16'd4;  run_res[1] = 16'd9;  run_res[2] = 16'd15;
        run_res[3] = 16'd22; run_res[4] = 16'd30;

        reset = 1'b1; cfg_start = 1'b0; cfg_coef = '0; cfg_valid = 1'b0;
        smp_in = '0; smp_valid = 1'b0; fir_data_out = '0; fir_out_enable = 1'b0;
        fir_error = 1'b0;
        step(); step();
        check_all_zero("reset");
        reset = 1'b0;

        // fir_error in IDLE is ignored.
        fir_error = 1'b1;
        step();
        fir_error = 1'b0;
        check("idle_err_flag", 32'(err_flag), 32'd0);
        check("idle_err_busy", 32'(busy), 32'd0);

        // Table-driven first load.
        for (int i = 0; i < 14; i++) begin
            cfg_start = vecs[i].start;
            cfg_valid = vecs[i].valid;
            cfg_coef  = vecs[i].coef;
            if (vecs[i].valid) coef_q.push_back(vecs[i].coef);
            step();
            check($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].e_cfg_ready));
            check($sformatf("v%0d_smp_ready", i), 32'(smp_ready), 32'(vecs[i].e_smp_ready));
            check($sformatf("v%0d_coef_en", i),   32'(fir_coef_enable), 32'(vecs[i].e_coef_en));
            check($sformatf("v%0d_data_in", i),   32'(fir_data_in), 32'(vecs[i].e_data));
            check($sformatf("v%0d_cfg_done", i),  32'(cfg_done), 32'(vecs[i].e_cfg_done));
            check($sformatf("v%0d_busy", i),      32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_smp_en", i),    32'(fir_sample_enable), 32'd0);
        end
        cfg_start = 1'b0; cfg_valid = 1'b0;

        // RUN: five samples of 1, then five FIR results.
        for (int k = 0; k < 5; k++) begin
            smp_valid = 1'b1; smp_in = 8'd1; smp_q.push_back(8'd1);
            step();
            check("run_smp_en", 32'(fir_sample_enable), 32'd1);
        end
        smp_valid = 1'b0;
        step();
        check("run_smp_en_idle", 32'(fir_sample_enable), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive_result(run_res[k]);
            check("run_res_valid", 32'(res_valid), 32'd1);
            check("run_out_count", 32'(out_count), 32'(k + 1));
            step();
            check("run_res_hold", 32'(res_data), 32'(run_res[k]));
        end
        check("run_out_count5", 32'(out_count), 32'd5);

        // cfg_start in RUN with a sample accepted the same cycle.
        cfg_start = 1'b1; smp_valid = 1'b1; smp_in = 8'h55; smp_q.push_back(8'h55);
        step();
        cfg_start = 1'b0; smp_valid = 1'b0;
        check("restart_smp_en", 32'(fir_sample_enable), 32'd1);
        check("restart_cfg_ready", 32'(cfg_ready), 32'd1);
        check("restart_smp_ready", 32'(smp_ready), 32'd0);
        check("restart_out_count", 32'(out_count), 32'd0);

        // Gapped load: valid every other cycle.
        for (int i = 0; i < 10; i++) begin
            drive_coef(8'(20 + i));
            check("gapped_coef_en", 32'(fir_coef_enable), 32'd1);
            check("gapped_cfg_ready", 32'(cfg_ready), 32'(i < 9));
            if (i < 9) begin
                step();
                check("gapped_stall_en", 32'(fir_coef_enable), 32'd0);
                check("gapped_stall_ready", 32'(cfg_ready), 32'd1);
            end
        end
        step();
        check("gapped_gap_done", 32'(cfg_done), 32'd0);
        check("gapped_gap_en", 32'(fir_coef_enable | fir_sample_enable), 32'd0);
        step();
        check("gapped_cfg_done", 32'(cfg_done), 32'd1);
        check("gapped_smp_ready", 32'(smp_ready), 32'd1);

        drive_result(16'd7);
        drive_result(16'd8);
        check("pre_err_count", 32'(out_count), 32'd2);

        // fir_error and cfg_start together: error wins.
        fir_error = 1'b1; cfg_start = 1'b1;
        step();
        fir_error = 1'b0; cfg_start = 1'b0;
        check("err_flag_set", 32'(err_flag), 32'd1);
        check("err_cfg_ready", 32'(cfg_ready), 32'd0);
        check("err_smp_ready", 32'(smp_ready), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        check("err_count_kept", 32'(out_count), 32'd2);
        fir_out_enable = 1'b1; fir_data_out = 16'd99;
        step();
        fir_out_enable = 1'b0;
        check("err_res_ignored", 32'(res_valid), 32'd0);
        check("err_res_hold", 32'(res_data), 32'd8);
        check("err_count_hold", 32'(out_count), 32'd2);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("err_exit_flag", 32'(err_flag), 32'd0);
        check("err_exit_count", 32'(out_count), 32'd0);
        check("err_exit_ready", 32'(cfg_ready), 32'd1);
        check("err_exit_busy", 32'(busy), 32'd1);

        // Reset mid-LOAD after three coefficients.
        for (int i = 0; i < 3; i++) drive_coef(8'(30 + i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("midreset");

        // A fresh load needs all ten coefficients again.
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_coef(8'(40 + i));
            check("reload_cfg_ready", 32'(cfg_ready), 32'(i < 9));
        end

        // Restart from GAP, then stall after two coefficients.
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("gap_restart_ready", 32'(cfg_ready), 32'd1);
        drive_coef(8'd60);
        drive_coef(8'd61);
`ifdef FIR_SEQ_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            step();
            check("timeout_not_yet", 32'(err_flag), 32'd0);
        end
        step();
        check("timeout_err_flag", 32'(err_flag), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_cfg_ready", 32'(cfg_ready), 32'd0);
`else
        for (int k = 0; k < 20; k++) step();
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_cfg_ready", 32'(cfg_ready), 32'd1);
        check("stall_err_flag", 32'(err_flag), 32'd0);
`endif

        step();
        check("coef_q_empty", 32'(coef_q.size()), 32'd0);
        check("smp_q_empty", 32'(smp_q.size()), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
